// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU control decoder side and alu_exec.
// The master drives the request fields, the slave (alu_exec) returns registered status and result.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             err;

    modport master (
        output start, op, a, b, shamt,
        input  busy, done, result, zero, overflow, err
    );

    modport slave (
        input  start, op, a, b, shamt,
        output busy, done, result, zero, overflow, err
    );
endinterface

// File: rtl/alu_exec.sv
// Registered ALU execution unit: single-cycle arithmetic/logic ops and an
// iterative one-bit-per-cycle shifter behind a start/busy/done handshake.
module alu_exec (
    input  logic       clk,
    input  logic       rst,
    alu_exec_if.slave  bus
);
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SW    = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SW-1:0]    cnt;
    logic             shift_left;

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_ovf_c;
    logic             alu_err_c;
    logic             is_shift_c;
    logic [WIDTH-1:0] acc_step_c;

    // Single-cycle result for the op currently presented; shifts by zero pass b through.
    always_comb begin
        sum_c      = bus.a + bus.b;
        diff_c     = bus.a - bus.b;
        alu_res_c  = '0;
        alu_ovf_c  = 1'b0;
        alu_err_c  = 1'b0;
        is_shift_c = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (diff_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res_c = bus.a & bus.b;
            OP_OR:  alu_res_c = bus.a | bus.b;
            OP_XOR: alu_res_c = bus.a ^ bus.b;
            OP_NOR: alu_res_c = ~(bus.a | bus.b);
            OP_SLL, OP_SRL: begin
                alu_res_c  = bus.b;
                is_shift_c = 1'b1;
            end
            default: alu_err_c = 1'b1;
        endcase
    end

    // One-bit shift step of the accumulator, zero fill in both directions.
    always_comb begin
        acc_step_c = shift_left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            shift_left   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                    if (bus.start) begin
                        if (is_shift_c && (bus.shamt != SW'(0))) begin
                            acc        <= bus.b;
                            cnt        <= bus.shamt;
                            shift_left <= (bus.op == OP_SLL);
                            bus.busy   <= 1'b1;
                            state      <= SHIFT;
                        end else begin
                            bus.result   <= alu_res_c;
                            bus.zero     <= (alu_res_c == '0);
                            bus.overflow <= alu_ovf_c;
                            bus.err      <= alu_err_c;
                            bus.done     <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_step_c;
                    cnt <= cnt - SW'(1);
                    // Final step: publish only the completed value, never intermediates.
                    if (cnt == SW'(1)) begin
                        bus.result   <= acc_step_c;
                        bus.zero     <= (acc_step_c == '0);
                        bus.overflow <= 1'b0;
                        bus.err      <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
